// File: rtl/gpk_sub_pipe.sv
// 8-bit pipelined subtractor (a - b) using a GPK prefix borrow chain, one prefix level per stage.
// Global-stall valid/ready flow control; results carry borrow, signed-overflow and zero flags.
module gpk_sub_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] diff,
  output logic       borrow,
  output logic       ovf,
  output logic       zero,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [1:0] GpkK = 2'b00;
  localparam logic [1:0] GpkP = 2'b01;
  localparam logic [1:0] GpkG = 2'b11;

  // Code 10 is never produced; it collapses to K.
  function automatic logic [1:0] combine(input logic [1:0] cur, input logic [1:0] prev);
    if (cur == GpkP)      return prev;
    else if (cur == GpkG) return GpkG;
    else                  return GpkK;
  endfunction

  logic            stall;
  logic [7:0][1:0] gpk1_d, gpk1_q, gpk2_d, gpk2_q, gpk4_d, gpk4_q, gpk8;
  logic [7:0]      isum_d, isum1_q, isum2_q, isum3_q;
  logic [2:0]      a7_q, b7_q;
  logic            v1_q, v2_q, v3_q, v4_q;
  logic [7:0]      carry;
  logic [7:0]      diff_d;
  logic            borrow_d, ovf_d, zero_d;

  assign stall     = v4_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v4_q;

  always_comb begin
    isum_d = a ^ ~b;
    for (int i = 0; i < 8; i++) begin
      if (a[i] & ~b[i])      gpk1_d[i] = GpkG;
      else if (a[i] ^ ~b[i]) gpk1_d[i] = GpkP;
      else                   gpk1_d[i] = GpkK;
    end
    // Fold the +1 carry-in: bit 0 propagate becomes generate.
    if (gpk1_d[0] == GpkP) gpk1_d[0] = GpkG;
  end

  always_comb begin
    gpk2_d[0] = gpk1_q[0];
    for (int i = 1; i < 8; i++) gpk2_d[i] = combine(gpk1_q[i], gpk1_q[i-1]);
    gpk4_d[1:0] = gpk2_q[1:0];
    for (int i = 2; i < 8; i++) gpk4_d[i] = combine(gpk2_q[i], gpk2_q[i-2]);
    gpk8[3:0] = gpk4_q[3:0];
    for (int i = 4; i < 8; i++) gpk8[i] = combine(gpk4_q[i], gpk4_q[i-4]);
  end

  always_comb begin
    for (int i = 0; i < 8; i++) carry[i] = (gpk8[i] == GpkG);
    diff_d   = isum3_q ^ {carry[6:0], 1'b1};
    borrow_d = ~carry[7];
    ovf_d    = (a7_q[2] != b7_q[2]) & (diff_d[7] != a7_q[2]);
    zero_d   = (diff_d == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpk1_q  <= '0;
      gpk2_q  <= '0;
      gpk4_q  <= '0;
      isum1_q <= '0;
      isum2_q <= '0;
      isum3_q <= '0;
      a7_q    <= '0;
      b7_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (!stall) begin
      gpk1_q  <= gpk1_d;
      gpk2_q  <= gpk2_d;
      gpk4_q  <= gpk4_d;
      isum1_q <= isum_d;
      isum2_q <= isum1_q;
      isum3_q <= isum2_q;
      a7_q    <= {a7_q[1:0], a[7]};
      b7_q    <= {b7_q[1:0], b[7]};
      v1_q    <= in_valid & in_ready;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      v4_q    <= v3_q;
      diff    <= diff_d;
      borrow  <= borrow_d;
      ovf     <= ovf_d;
      zero    <= zero_d;
    end
  end

endmodule
